// File: rtl/des_pkg.sv
// des_pkg -- shared DES constants and helpers for the iterative DES engines.
//
// Contents:
//   state_e    controller states (idle, running rounds, completion pulse)
//   IP_T/FP_T  initial / final permutation tables (DES 1-based bit numbers)
//   E_T, P_T   f-function expansion and permutation tables
//   PC1_T/PC2_T key-schedule permuted-choice tables
//   SBOX       S1..S8, 64 entries each, indexed by {b1,b6,b2..b5}
//   ROT_T      right-rotation amount per decrypt round 1..16
//   helpers    table-driven permutations, 28-bit right rotate, key parity
//
// Bit numbering: a DES vector of width W holds DES bit n at index W-n, so
// DES bit 1 is always the MSB.
package des_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_ROUND, ST_DONE} state_e;

  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7};

  localparam int FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25};

  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  // Decrypt schedule: the encrypt left shifts total 28, so rotating right by
  // the encrypt shifts in reverse order (starting with 0) walks K16..K1.
  localparam int ROT_T [16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  localparam int SBOX [8][64] = '{
    '{14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7,
       0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8,
       4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0,
      15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13},
    '{15,  1,  8, 14,  6, 11,  3,  4,  9,  7,  2, 13, 12,  0,  5, 10,
       3, 13,  4,  7, 15,  2,  8, 14, 12,  0,  1, 10,  6,  9, 11,  5,
       0, 14,  7, 11, 10,  4, 13,  1,  5,  8, 12,  6,  9,  3,  2, 15,
      13,  8, 10,  1,  3, 15,  4,  2, 11,  6,  7, 12,  0,  5, 14,  9},
    '{10,  0,  9, 14,  6,  3, 15,  5,  1, 13, 12,  7, 11,  4,  2,  8,
      13,  7,  0,  9,  3,  4,  6, 10,  2,  8,  5, 14, 12, 11, 15,  1,
      13,  6,  4,  9,  8, 15,  3,  0, 11,  1,  2, 12,  5, 10, 14,  7,
       1, 10, 13,  0,  6,  9,  8,  7,  4, 15, 14,  3, 11,  5,  2, 12},
    '{ 7, 13, 14,  3,  0,  6,  9, 10,  1,  2,  8,  5, 11, 12,  4, 15,
      13,  8, 11,  5,  6, 15,  0,  3,  4,  7,  2, 12,  1, 10, 14,  9,
      10,  6,  9,  0, 12, 11,  7, 13, 15,  1,  3, 14,  5,  2,  8,  4,
       3, 15,  0,  6, 10,  1, 13,  8,  9,  4,  5, 11, 12,  7,  2, 14},
    '{ 2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9,
      14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6,
       4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14,
      11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3},
    '{12,  1, 10, 15,  9,  2,  6,  8,  0, 13,  3,  4, 14,  7,  5, 11,
      10, 15,  4,  2,  7, 12,  9,  5,  6,  1, 13, 14,  0, 11,  3,  8,
       9, 14, 15,  5,  2,  8, 12,  3,  7,  0,  4, 10,  1, 13, 11,  6,
       4,  3,  2, 12,  9,  5, 15, 10, 11, 14,  1,  7,  6,  0,  8, 13},
    '{ 4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1,
      13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6,
       1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2,
       6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12},
    '{13,  2,  8,  4,  6, 15, 11,  1, 10,  9,  3, 14,  5,  0, 12,  7,
       1, 15, 13,  8, 10,  3,  7,  4, 12,  5,  6, 11,  0, 14,  9,  2,
       7, 11,  4,  1,  9, 12, 14,  2,  0,  6, 10, 13, 15,  3,  5,  8,
       2,  1, 14,  7,  4, 10,  8, 13, 15, 12,  9,  0,  3,  5,  6, 11}};

  // Each permutation: output DES bit i+1 takes input DES bit TABLE[i].
  function automatic logic [63:0] ip_perm(input logic [63:0] x);
    for (int i = 0; i < 64; i++) ip_perm[6'(63 - i)] = x[6'(64 - IP_T[6'(i)])];
  endfunction

  function automatic logic [63:0] fp_perm(input logic [63:0] x);
    for (int i = 0; i < 64; i++) fp_perm[6'(63 - i)] = x[6'(64 - FP_T[6'(i)])];
  endfunction

  function automatic logic [47:0] e_exp(input logic [31:0] x);
    for (int i = 0; i < 48; i++) e_exp[6'(47 - i)] = x[5'(32 - E_T[6'(i)])];
  endfunction

  function automatic logic [31:0] p_perm(input logic [31:0] x);
    for (int i = 0; i < 32; i++) p_perm[5'(31 - i)] = x[5'(32 - P_T[5'(i)])];
  endfunction

  // Parity bits (DES bits 8,16,..,64) are simply never selected.
  function automatic logic [55:0] pc1(input logic [63:0] k);
    for (int i = 0; i < 56; i++) pc1[6'(55 - i)] = k[6'(64 - PC1_T[6'(i)])];
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    for (int i = 0; i < 48; i++) pc2[6'(47 - i)] = cd[6'(56 - PC2_T[6'(i)])];
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input int n);
    case (n)
      1:       rotr28 = {x[0], x[27:1]};
      2:       rotr28 = {x[1:0], x[27:2]};
      default: rotr28 = x;
    endcase
  endfunction

  // True when every key byte has odd parity.
  function automatic logic key_parity_ok(input logic [63:0] k);
    key_parity_ok = 1'b1;
    for (int b = 0; b < 8; b++) begin
      if (!(^k[8*b +: 8])) key_parity_ok = 1'b0;
    end
  endfunction

endpackage

// File: rtl/des_round_f.sv
// des_round_f -- combinational DES f-function, shared with the encrypt path.
//
// Ports:
//   r_in    [31:0]  right half R (DES bit 1 = MSB)
//   subkey  [47:0]  round subkey
//   f_out   [31:0]  P(S(E(R) xor subkey))
module des_round_f
  import des_pkg::*;
(
  input  logic [31:0] r_in,
  input  logic [47:0] subkey,
  output logic [31:0] f_out
);

  logic [47:0] x;
  logic [31:0] s_out;

  assign x = e_exp(r_in) ^ subkey;

  for (genvar g = 0; g < 8; g++) begin : g_sbox
    logic [5:0] six;
    assign six = x[47 - 6*g -: 6];
    // Row is the outer bit pair b1,b6; column is the inner four bits.
    assign s_out[31 - 4*g -: 4] = 4'(SBOX[g][{six[5], six[0], six[4:1]}]);
  end

  assign f_out = p_perm(s_out);

endmodule

// File: rtl/des_decrypt_core.sv
// des_decrypt_core -- iterative DES decryption, one Feistel round per clock.
//
// Ports:
//   CLK              system clock, rising edge
//   RST              synchronous, active-high reset (overrides everything)
//   CHIP_SELECT_BAR  active-low enable; high stalls rounds and blocks starts
//   START            request strobe, accepted in idle/done when selected
//   CIPHER_TEXT      [64:1] ciphertext, captured on the accepting edge
//   KEY              [64:1] key with parity bits, captured on acceptance
//   PLAIN_TEXT       [64:1] registered result, held until next completion
//   BUSY             high while rounds are in progress
//   DONE             one-cycle pulse when PLAIN_TEXT is updated
//   KEY_PARITY_ERR   (DES_KEY_PARITY_CHECK_EN only) one-cycle pulse when a
//                    start is refused because a key byte has even parity
//
// Build option: define DES_KEY_PARITY_CHECK_EN to enable key parity checking.
module des_decrypt_core
  import des_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        CHIP_SELECT_BAR,
  input  logic        START,
  input  logic [64:1] CIPHER_TEXT,
  input  logic [64:1] KEY,
  output logic [64:1] PLAIN_TEXT,
  output logic        BUSY,
  output logic        DONE
`ifdef DES_KEY_PARITY_CHECK_EN
  ,
  output logic        KEY_PARITY_ERR
`endif
);

  state_e      state_q, state_d;
  logic [4:0]  round_q, round_d;
  logic [31:0] l_q, l_d, r_q, r_d;
  logic [27:0] c_q, c_d, d_q, d_d;
  logic [63:0] pt_q, pt_d;

  logic [27:0] c_rot, d_rot;
  logic [47:0] subkey;
  logic [31:0] f_out, r_new;
  logic        start_req, key_ok;

  // Round j rotates the stored C/D right by ROT_T[j-1] before PC2; round 16
  // wraps the 4-bit index to 15 so the lookup needs no extra logic.
  assign c_rot  = rotr28(c_q, ROT_T[round_q[3:0] - 4'd1]);
  assign d_rot  = rotr28(d_q, ROT_T[round_q[3:0] - 4'd1]);
  assign subkey = pc2({c_rot, d_rot});
  assign r_new  = l_q ^ f_out;

  des_round_f u_round_f (
    .r_in   (r_q),
    .subkey (subkey),
    .f_out  (f_out)
  );

  assign start_req = START && !CHIP_SELECT_BAR && (state_q != ST_ROUND);

`ifdef DES_KEY_PARITY_CHECK_EN
  logic perr_q, perr_d;
  assign key_ok         = key_parity_ok(KEY);
  assign KEY_PARITY_ERR = perr_q;
`else
  assign key_ok = 1'b1;
`endif

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_d = state_q;
    round_d = round_q;
    l_d     = l_q;
    r_d     = r_q;
    c_d     = c_q;
    d_d     = d_q;
    pt_d    = pt_q;
`ifdef DES_KEY_PARITY_CHECK_EN
    perr_d  = start_req && !key_ok;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start_req && key_ok) begin
          {l_d, r_d} = ip_perm(CIPHER_TEXT);
          {c_d, d_d} = pc1(KEY);
          round_d    = 5'd1;
          state_d    = ST_ROUND;
        end
      end
      ST_ROUND: begin
        if (!CHIP_SELECT_BAR) begin
          l_d = r_q;
          r_d = r_new;
          c_d = c_rot;
          d_d = d_rot;
          if (round_q == 5'd16) begin
            // Final round: undo the last swap, R16 || L16, then FP.
            pt_d    = fp_perm({r_new, r_q});
            state_d = ST_DONE;
          end else begin
            round_d = round_q + 5'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    // NOTE: registers take non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (RST) begin
      state_q <= ST_IDLE;
      round_q <= '0;
      l_q     <= '0;
      r_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      pt_q    <= '0;
`ifdef DES_KEY_PARITY_CHECK_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      l_q     <= l_d;
      r_q     <= r_d;
      c_q     <= c_d;
      d_q     <= d_d;
      pt_q    <= pt_d;
`ifdef DES_KEY_PARITY_CHECK_EN
      perr_q  <= perr_d;
`endif
    end
  end

  assign PLAIN_TEXT = pt_q;
  assign BUSY       = (state_q == ST_ROUND);
  assign DONE       = (state_q == ST_DONE);

endmodule

// File: tb/tb_des_decrypt_core.sv
// tb_des_decrypt_core -- self-checking bench for des_decrypt_core.
// The reference model is a plain DES encrypt/decrypt built from the standard
// left-shift key schedule; it stands in for Des_Top in the round-trip test.
module tb_des_decrypt_core;
  import des_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cs_bar = 1'b0;
  logic        start = 1'b1;
  logic [64:1] cipher_text = '0;
  logic [64:1] key = '0;
  logic [64:1] plain_text;
  logic        busy, done;
`ifdef DES_KEY_PARITY_CHECK_EN
  logic        key_parity_err;
`endif

  int n_vec = 0;
  int n_err = 0;

  localparam logic [63:0] KAT_KEY = 64'h133457799BBCDFF1;
  localparam logic [63:0] KAT_CT  = 64'h85E813540F0AB405;
  localparam logic [63:0] KAT_PT  = 64'h0123456789ABCDEF;
  localparam logic [63:0] WK_KEY  = 64'h0101010101010101;

  des_decrypt_core dut (
    .CLK             (clk),
    .RST             (rst),
    .CHIP_SELECT_BAR (cs_bar),
    .START           (start),
    .CIPHER_TEXT     (cipher_text),
    .KEY             (key),
    .PLAIN_TEXT      (plain_text),
    .BUSY            (busy),
    .DONE            (done)
`ifdef DES_KEY_PARITY_CHECK_EN
    ,
    .KEY_PARITY_ERR  (key_parity_err)
`endif
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int tb_tbl(input int which, input int i);
    case (which)
      0:       return IP_T[i[5:0]];
      1:       return FP_T[i[5:0]];
      2:       return E_T[i[5:0]];
      3:       return P_T[i[4:0]];
      4:       return PC1_T[i[5:0]];
      default: return PC2_T[i[5:0]];
    endcase
  endfunction

  // Output DES bit i+1 = input DES bit tbl[i]; DES bit n of a w-bit word is
  // at index w-n.
  function automatic logic [63:0] tb_perm(input logic [63:0] x, input int in_w,
                                          input int out_w, input int which);
    logic [63:0] y;
    int s, d;
    y = '0;
    for (int i = 0; i < out_w; i++) begin
      s = in_w - tb_tbl(which, i);
      d = out_w - 1 - i;
      y[d[5:0]] = x[s[5:0]];
    end
    return y;
  endfunction

  function automatic logic [31:0] tb_f(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] e;
    logic [5:0]  six;
    logic [31:0] s;
    int          v;
    e = tb_perm({32'h0, r}, 32, 48, 2)[47:0] ^ k;
    s = '0;
    for (int b = 0; b < 8; b++) begin
      six = 6'(e >> (42 - 6 * b));
      v   = SBOX[b[2:0]][{six[5], six[0], six[4:1]}];
      s   = (s << 4) | 32'(v);
    end
    return tb_perm({32'h0, s}, 32, 32, 3)[31:0];
  endfunction

  function automatic logic [63:0] tb_des(input logic [63:0] blk, input logic [63:0] k,
                                         input bit decrypt);
    int          shifts [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    logic [47:0] ks [16];
    logic [55:0] cd;
    logic [27:0] c, d;
    logic [63:0] lr;
    logic [31:0] l, r, t;
    int          idx;
    cd = tb_perm(k, 64, 56, 4)[55:0];
    c  = cd[55:28];
    d  = cd[27:0];
    for (int j = 0; j < 16; j++) begin
      for (int s = 0; s < shifts[j[3:0]]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      ks[j[3:0]] = tb_perm({8'h0, c, d}, 56, 48, 5)[47:0];
    end
    lr = tb_perm(blk, 64, 64, 0);
    l  = lr[63:32];
    r  = lr[31:0];
    for (int j = 0; j < 16; j++) begin
      idx = decrypt ? 15 - j : j;
      t   = r;
      r   = l ^ tb_f(r, ks[idx[3:0]]);
      l   = t;
    end
    return tb_perm({r, l}, 64, 64, 1);
  endfunction

  function automatic logic [63:0] fix_parity(input logic [63:0] k);
    logic [63:0] y;
    y = k;
    for (int b = 0; b < 8; b++) y[8*b] = ~^y[8*b+1 +: 7];
    return y;
  endfunction

  // ---------------- operation driver ----------------
  // Call at a negedge. Starts an operation, optionally stalls for stall_len
  // cycles beginning stall_at cycles after acceptance, fires ignored START
  // pulses while busy, and returns at the negedge where DONE is seen.
  task automatic run_op(input logic [63:0] ct, input logic [63:0] k,
                        input int stall_at, input int stall_len,
                        output int lat, output int busy_cnt,
                        output bit got_done, output logic [63:0] mid_pt);
    cipher_text = ct;
    key         = k;
    start       = 1'b1;
    cs_bar      = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start       = 1'b0;
    cipher_text = {$urandom, $urandom};
    key         = {$urandom, $urandom};
    lat = 0; busy_cnt = 0; got_done = 1'b0; mid_pt = '0;
    while (!got_done && lat < 64) begin
      if (busy) busy_cnt++;
      if (lat == 8) mid_pt = plain_text;
      cs_bar = (lat >= stall_at) && (lat < stall_at + stall_len);
      start  = (lat == 3) || (lat == 11);
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (done) got_done = 1'b1;
    end
    start  = 1'b0;
    cs_bar = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", done); end
    n_vec++; if (plain_text !== 64'h0) begin n_err++; $display("FAIL reset_pt got=%h exp=0", plain_text); end
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_known_answer();
    int lat, bc; bit got; logic [63:0] mid;
    run_op(KAT_CT, KAT_KEY, 99, 0, lat, bc, got, mid);
    n_vec++; if (!got) begin n_err++; $display("FAIL kat_done got=timeout exp=done"); end
    n_vec++; if (lat != 16) begin n_err++; $display("FAIL kat_latency got=%0d exp=16", lat); end
    n_vec++; if (bc != 16) begin n_err++; $display("FAIL kat_busy_cycles got=%0d exp=16", bc); end
    n_vec++; if (plain_text !== KAT_PT) begin n_err++; $display("FAIL kat_pt got=%h exp=%h", plain_text, KAT_PT); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL kat_busy_at_done got=%b exp=0", busy); end
    @(negedge clk);
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL kat_done_pulse got=%b exp=0", done); end
    n_vec++; if (plain_text !== KAT_PT) begin n_err++; $display("FAIL kat_pt_hold got=%h exp=%h", plain_text, KAT_PT); end
  endtask

  task automatic test_stall();
    int lat, bc; bit got; logic [63:0] mid;
    run_op(KAT_CT, KAT_KEY, 6, 5, lat, bc, got, mid);
    n_vec++; if (!got) begin n_err++; $display("FAIL stall_done got=timeout exp=done"); end
    n_vec++; if (lat != 21) begin n_err++; $display("FAIL stall_latency got=%0d exp=21", lat); end
    n_vec++; if (bc != 21) begin n_err++; $display("FAIL stall_busy_cycles got=%0d exp=21", bc); end
    n_vec++; if (mid !== KAT_PT) begin n_err++; $display("FAIL stall_pt_hold got=%h exp=%h", mid, KAT_PT); end
    n_vec++; if (plain_text !== KAT_PT) begin n_err++; $display("FAIL stall_pt got=%h exp=%h", plain_text, KAT_PT); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int lat, bc; bit got; logic [63:0] mid;
    run_op(64'h95F8A5E5DD31D900, WK_KEY, 99, 0, lat, bc, got, mid);
    n_vec++; if (plain_text !== 64'h8000000000000000) begin n_err++; $display("FAIL weak1_pt got=%h exp=8000000000000000", plain_text); end
    run_op(64'hDD7F121CA5015619, WK_KEY, 99, 0, lat, bc, got, mid);
    n_vec++; if (!got) begin n_err++; $display("FAIL b2b_done got=timeout exp=done"); end
    n_vec++; if (lat != 16) begin n_err++; $display("FAIL b2b_latency got=%0d exp=16", lat); end
    n_vec++; if (mid !== 64'h8000000000000000) begin n_err++; $display("FAIL b2b_pt_hold got=%h exp=8000000000000000", mid); end
    n_vec++; if (plain_text !== 64'h4000000000000000) begin n_err++; $display("FAIL weak2_pt got=%h exp=4000000000000000", plain_text); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    int lat, bc, n_done; bit got; logic [63:0] mid;
    cipher_text = KAT_CT;
    key         = KAT_KEY;
    start       = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL rst_mid_done got=%b exp=0", done); end
    n_vec++; if (plain_text !== 64'h0) begin n_err++; $display("FAIL rst_mid_pt got=%h exp=0", plain_text); end
    rst = 1'b0;
    n_done = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) n_done++;
    end
    n_vec++; if (n_done != 0) begin n_err++; $display("FAIL rst_mid_no_done got=%0d exp=0", n_done); end
    run_op(KAT_CT, KAT_KEY, 99, 0, lat, bc, got, mid);
    n_vec++; if (lat != 16) begin n_err++; $display("FAIL rst_restart_latency got=%0d exp=16", lat); end
    n_vec++; if (plain_text !== KAT_PT) begin n_err++; $display("FAIL rst_restart_pt got=%h exp=%h", plain_text, KAT_PT); end
    @(negedge clk);
  endtask

  task automatic test_round_trip();
    int lat, bc, s_at, s_len; bit got; logic [63:0] mid, k, p, ct;
    for (int n = 0; n < 100; n++) begin
      k  = fix_parity({$urandom, $urandom});
      p  = {$urandom, $urandom};
      ct = tb_des(p, k, 1'b0);
      if ($urandom_range(0, 3) == 0) begin
        s_at  = $urandom_range(0, 15);
        s_len = $urandom_range(1, 4);
      end else begin
        s_at  = 99;
        s_len = 0;
      end
      run_op(ct, k, s_at, s_len, lat, bc, got, mid);
      n_vec++; if (plain_text !== p) begin n_err++; $display("FAIL rt_pt[%0d] key=%h got=%h exp=%h", n, k, plain_text, p); end
      n_vec++; if (lat != 16 + s_len) begin n_err++; $display("FAIL rt_latency[%0d] got=%0d exp=%0d", n, lat, 16 + s_len); end
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
    @(negedge clk);
  endtask

`ifdef DES_KEY_PARITY_CHECK_EN
  task automatic test_key_parity();
    int lat, bc; bit got; logic [63:0] mid;
    cipher_text = 64'h95F8A5E5DD31D900;
    key         = 64'h0001010101010101;
    start       = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n_vec++; if (key_parity_err !== 1'b1) begin n_err++; $display("FAIL parity_err got=%b exp=1", key_parity_err); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL parity_busy got=%b exp=0", busy); end
    @(negedge clk);
    n_vec++; if (key_parity_err !== 1'b0) begin n_err++; $display("FAIL parity_pulse got=%b exp=0", key_parity_err); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL parity_busy2 got=%b exp=0", busy); end
    run_op(64'h95F8A5E5DD31D900, WK_KEY, 99, 0, lat, bc, got, mid);
    n_vec++; if (plain_text !== 64'h8000000000000000) begin n_err++; $display("FAIL parity_ok_pt got=%h exp=8000000000000000", plain_text); end
    n_vec++; if (key_parity_err !== 1'b0) begin n_err++; $display("FAIL parity_ok_err got=%b exp=0", key_parity_err); end
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_known_answer();
    test_stall();
    test_back_to_back();
    test_reset_mid_op();
    test_round_trip();
`ifdef DES_KEY_PARITY_CHECK_EN
    test_key_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "simulation watchdog expired");
  end

endmodule

// File: doc/des_decrypt_core.md
Name: des_decrypt_core

Overview:
Iterative single-round-per-clock DES decryption engine; the inverse-direction companion to Des_Top, which performs encryption.
- Accepts a 64-bit CIPHER_TEXT and 64-bit KEY on a START handshake and runs 16 Feistel rounds with subkeys in reverse order (K16..K1).
- Presents PLAIN_TEXT with a one-cycle DONE pulse.
- Sits beside Des_Top in the crypto datapath and shares its bit numbering: [64:1], bit 64 = DES bit 1.

Parameters:
- None. The DES geometry is fixed and its constants live in the package.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  synchronous, active-high reset.
- CHIP_SELECT_BAR  input  1  active-low enable; high = block deselected.
- START  input  1  request strobe, sampled on CLK edge.
- CIPHER_TEXT  input  [64:1]  ciphertext block; captured when START is accepted.
- KEY  input  [64:1]  DES key including parity bits; captured when START is accepted.
- PLAIN_TEXT  output  [64:1]  decrypted block, registered.
- BUSY  output  1  high while rounds are in progress.
- DONE  output  1  one-cycle pulse; PLAIN_TEXT is valid from this cycle onward.

Behaviour:
- Clock and reset: one clock (CLK). RST is synchronous and active-high; it takes priority over every other input.
- Reset values: state=IDLE, round counter=0, L/R/C/D registers=0, PLAIN_TEXT=0, BUSY=0, DONE=0.
- States: IDLE, ROUND, DONE.
- Start acceptance: START=1 and CHIP_SELECT_BAR=0 in IDLE or DONE accepts the request. Call that accepting edge k.
  - At edge k: load L0R0 = IP(CIPHER_TEXT); load C0D0 = PC1(KEY); round counter=1; go to ROUND; BUSY=1.
- Round j (j=1..16, edges k+1..k+16):
  - Subkey = PC2(C,D), where C,D are first rotated right by rot[j] = 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - The rotation is combinational before PC2, so round 1 uses PC2(C0D0) = K16.
  - L' = R; R' = L xor f(R, subkey).
- After round 16 (edge k+16):
  - PLAIN_TEXT = FP(R16 || L16), with the swap undone.
  - DONE=1 for exactly one cycle; BUSY=0; state=DONE.
- Latency: DONE is high in the cycle after edge k+16, i.e. 16 cycles after the accepting edge.
- DONE state: returns to IDLE on the next edge unless a new START is accepted there, which gives back-to-back operation with DONE deasserting.
- PLAIN_TEXT hold: retains its value until the next completion or RST. It is not cleared when a new start is accepted.
- START while in ROUND: ignored, no queuing. CIPHER_TEXT and KEY changes after acceptance have no effect.
- CHIP_SELECT_BAR=1 during ROUND: stall. All registers hold, the round counter does not advance, BUSY stays 1. Resumes when it returns low.
- CHIP_SELECT_BAR=1 with START=1: not accepted.
- RST mid-operation: abort to reset values the next edge; no DONE.
- Round counter: 5 bits; it never wraps past 16.

Optional Feature:
Macro DES_KEY_PARITY_CHECK_EN.
- Defined:
  - Adds output KEY_PARITY_ERR (1 bit, reset 0).
  - On a START that would otherwise be accepted, if any KEY byte has even parity: the start is refused, the block stays in IDLE, and KEY_PARITY_ERR=1 for one cycle (no BUSY/DONE).
  - A valid start clears the flag.
- Undefined: the port is absent and parity bits are ignored (dropped by PC1).

Decomposition:
- Package des_pkg holds:
  - IP, FP, E, P, PC1, PC2 permutation tables.
  - S-boxes S1..S8.
  - The decrypt rotation table rot[1..16].
  - State enum {IDLE, ROUND, DONE}.
  - Helper functions for permute/rotate.
- Sub-module des_round_f: combinational f-function. Inputs are R[32] and subkey[48]; it applies expansion E, XOR, the S-boxes and P to produce out[32]. It is shared with the encrypt path.

Test Plan:
- Known answer: RST, then START with KEY=133457799BBCDFF1, CIPHER_TEXT=85E813540F0AB405 -> DONE after 16 cycles, PLAIN_TEXT=0123456789ABCDEF, BUSY high for exactly 16 cycles.
- Weak key: KEY=0101010101010101, CIPHER_TEXT=95F8A5E5DD31D900 -> PLAIN_TEXT=8000000000000000. A second back-to-back start from the DONE state with CIPHER_TEXT=DD7F121CA5015619 -> 4000000000000000, DONE 16 cycles later.
- Stall: in the known-answer run, hold CHIP_SELECT_BAR=1 for 5 cycles mid-round -> DONE at 21 cycles, same PLAIN_TEXT. START pulses during BUSY are ignored.
- Reset mid-op: RST at round 8 -> next cycle BUSY=0, PLAIN_TEXT=0, no DONE. A fresh start then completes correctly.
- Round trip: 100 random KEY/plaintext pairs encrypted by Des_Top and fed back to the decryptor -> each PLAIN_TEXT matches the original.
- With DES_KEY_PARITY_CHECK_EN: KEY=0001010101010101 -> KEY_PARITY_ERR pulse, BUSY stays 0. KEY=0101010101010101 is accepted.
